data_mem_port: RTL and testbench

Load/store port between the single-cycle core's execute stage and a synchronous word-wide data SRAM. Consumes the 3-bit `datarw` access code produced by the control unit together with the ALU address and rs2 data. Performs byte/half/word loads (signed and unsigned) and stores with byte enables, splitting misaligned accesses into two word beats. Returns extended load data with a one-cycle `done` pulse, and stalls the core via `busy` while an access is in flight.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/data_mem_port_if.sv | 28 ++
 rtl/lsu_align.sv | 43 ++++
 rtl/data_mem_port.sv | 118 +++++++++++
 tb/tb_data_mem_port.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: access codes, FSM states and size helpers for the data memory port
package lsu_pkg;

    localparam logic [2:0] DRW_LB  = 3'b000;
    localparam logic [2:0] DRW_LH  = 3'b001;
    localparam logic [2:0] DRW_LBU = 3'b010;
    localparam logic [2:0] DRW_LHU = 3'b011;
    localparam logic [2:0] DRW_LW  = 3'b100;
    localparam logic [2:0] DRW_SB  = 3'b101;
    localparam logic [2:0] DRW_SH  = 3'b110;
    localparam logic [2:0] DRW_SW  = 3'b111;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    function automatic logic [2:0] drw_size(input logic [2:0] drw);
        return (drw == DRW_LB || drw == DRW_LBU || drw == DRW_SB) ? 3'd1 :
               (drw == DRW_LH || drw == DRW_LHU || drw == DRW_SH) ? 3'd2 : 3'd4;
    endfunction

    function automatic logic is_store(input logic [2:0] drw);
        return drw[2] & (drw[1] | drw[0]);
    endfunction

endpackage

// File: rtl/data_mem_port_if.sv
// data_mem_port_if: core-side load/store request and SRAM bus of the data memory port
interface data_mem_port_if #(parameter int ADDR_W = 32, parameter int WORD_AW = 10);

    logic               req;
    logic [2:0]         datarw;
    logic [ADDR_W-1:0]  addr;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               done;
    logic               busy;
    logic               sram_en;
    logic               sram_we;
    logic [3:0]         sram_be;
    logic [WORD_AW-1:0] sram_addr;
    logic [31:0]        sram_wdata;
    logic [31:0]        sram_rdata;

    modport master (
        output req, datarw, addr, wdata, sram_rdata,
        input  rdata, done, busy, sram_en, sram_we, sram_be, sram_addr, sram_wdata
    );

    modport slave (
        input  req, datarw, addr, wdata, sram_rdata,
        output rdata, done, busy, sram_en, sram_we, sram_be, sram_addr, sram_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store data lane shifting and load extract/extend
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  drw,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] b0,
    input  logic [31:0] b1,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic        split,
    output logic [31:0] wd0,
    output logic [31:0] wd1,
    output logic [31:0] rdata
);

    logic [2:0]  n;
    logic [7:0]  m;
    logic [31:0] wm;
    logic [63:0] wsh;
    logic [31:0] rsh;

    // lane masks over the two-word window, store shifting and load extension
    always_comb begin
        n     = drw_size(drw);
        m     = ((8'd1 << n) - 8'd1) << off;
        be0   = m[3:0];
        be1   = m[7:4];
        split = |m[7:4];
        wm    = n == 3'd1 ? {24'b0, wdata[7:0]} : n == 3'd2 ? {16'b0, wdata[15:0]} : wdata;
        wsh   = {32'b0, wm} << {off, 3'b000};
        wd0   = wsh[31:0];
        wd1   = wsh[63:32];
        rsh   = 32'({b1, b0} >> {off, 3'b000});
        rdata = drw == DRW_LB  ? {{24{rsh[7]}}, rsh[7:0]} :
                drw == DRW_LH  ? {{16{rsh[15]}}, rsh[15:0]} :
                drw == DRW_LBU ? {24'b0, rsh[7:0]} :
                drw == DRW_LHU ? {16'b0, rsh[15:0]} :
                drw == DRW_LW  ? rsh : 32'b0;
    end

endmodule

// File: rtl/data_mem_port.sv
// data_mem_port: load/store port splitting misaligned accesses into two SRAM beats
module data_mem_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int WORD_AW = 10
) (
    input logic          clk,
    input logic          rst,
    data_mem_port_if.slave bus
);

    state_t             state, state_n;
    logic [2:0]         drw_q, a_drw;
    logic [WORD_AW+1:0] addr_q, a_addr;
    logic [31:0]        wdata_q, a_wdata, b0_q;
    logic               split_q;
    logic               en_q, we_q, en_n, we_n;
    logic [3:0]         be_q, be_n;
    logic [WORD_AW-1:0] sa_q, sa_n, word;
    logic [31:0]        wd_q, wd_n;
    logic [3:0]         be0, be1;
    logic               split;
    logic [31:0]        wd0, wd1, ld;
    logic               unused_addr;

    assign unused_addr = ^bus.addr[ADDR_W-1:WORD_AW+2];
    assign a_drw   = state == IDLE ? bus.datarw : drw_q;
    assign a_addr  = state == IDLE ? bus.addr[WORD_AW+1:0] : addr_q;
    assign a_wdata = state == IDLE ? bus.wdata : wdata_q;
    assign word    = a_addr[WORD_AW+1:2];

    lsu_align u_align (
        .drw   (a_drw),
        .off   (a_addr[1:0]),
        .wdata (a_wdata),
        .b0    (split_q ? b0_q : bus.sram_rdata),
        .b1    (split_q ? bus.sram_rdata : 32'b0),
        .be0   (be0),
        .be1   (be1),
        .split (split),
        .wd0   (wd0),
        .wd1   (wd1),
        .rdata (ld)
    );

    // next state and the SRAM strobes to register for the coming beat
    always_comb begin
        state_n = state;
        en_n    = 1'b0;
        we_n    = 1'b0;
        be_n    = 4'b0;
        sa_n    = sa_q;
        wd_n    = wd_q;
        case (state)
            IDLE: if (bus.req) begin
                state_n = BEAT0;
                en_n    = 1'b1;
                we_n    = is_store(a_drw);
                be_n    = be0;
                sa_n    = word;
                wd_n    = wd0;
            end
            BEAT0: begin
                state_n = split_q ? BEAT1 : RESP;
                en_n    = split_q;
                we_n    = split_q & is_store(a_drw);
                be_n    = split_q ? be1 : 4'b0;
                sa_n    = split_q ? word + 1'b1 : sa_q;
                wd_n    = split_q ? wd1 : wd_q;
            end
            BEAT1: state_n = RESP;
            RESP:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state, registered SRAM outputs, captured request and first read beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0;
            sa_q    <= '0;
            wd_q    <= 32'b0;
            drw_q   <= 3'b0;
            addr_q  <= '0;
            wdata_q <= 32'b0;
            split_q <= 1'b0;
            b0_q    <= 32'b0;
        end else begin
            state <= state_n;
            en_q  <= en_n;
            we_q  <= we_n;
            be_q  <= be_n;
            sa_q  <= sa_n;
            wd_q  <= wd_n;
            if (state == IDLE && bus.req) begin
                drw_q   <= bus.datarw;
                addr_q  <= bus.addr[WORD_AW+1:0];
                wdata_q <= bus.wdata;
                split_q <= split;
            end
            if (state == BEAT1) b0_q <= bus.sram_rdata;
        end
    end

    assign bus.busy       = state != IDLE;
    assign bus.done       = state == RESP;
    assign bus.rdata      = state == RESP ? ld : 32'b0;
    assign bus.sram_en    = en_q;
    assign bus.sram_we    = we_q;
    assign bus.sram_be    = be_q;
    assign bus.sram_addr  = sa_q;
    assign bus.sram_wdata = wd_q;

endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: directed load/store vectors against a behavioural word SRAM
module tb_data_mem_port;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_port_if #(.ADDR_W(32), .WORD_AW(10)) bus ();

    data_mem_port #(.ADDR_W(32), .WORD_AW(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:1023] = '{default: 32'b0};
    logic [31:0] beats = 32'd0;
    logic [9:0]  log_addr [0:7];
    logic [3:0]  log_be   [0:7];
    logic [31:0] log_wd   [0:7];
    logic        log_we   [0:7];

    // SRAM model with one-cycle read latency plus a log of every beat
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) begin
                for (int i = 0; i < 4; i++)
                    if (bus.sram_be[i]) mem[bus.sram_addr][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
            end else begin
                bus.sram_rdata <= mem[bus.sram_addr];
            end
            log_addr[beats[2:0]] <= bus.sram_addr;
            log_be[beats[2:0]]   <= bus.sram_be;
            log_wd[beats[2:0]]   <= bus.sram_wdata;
            log_we[beats[2:0]]   <= bus.sram_we;
            beats <= beats + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int lat, nb;
    logic [31:0] got, first;
    logic busy_ok, seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic [2:0] d, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] st;
        @(negedge clk);
        bus.req = 1'b1; bus.datarw = d; bus.addr = a; bus.wdata = w;
        st = beats;
        @(posedge clk);
        #1 bus.req = 1'b0;
        lat = 0; got = 32'hx; busy_ok = 1'b1;
        for (int i = 1; i <= 6 && lat == 0; i++) begin
            @(negedge clk);
            busy_ok &= bus.busy;
            if (bus.done) begin lat = i; got = bus.rdata; end
        end
        nb = int'(beats - st);
        first = st;
    endtask

    function automatic logic [2:0] ix(input logic [31:0] base, input int k);
        logic [31:0] s;
        s = base + k;
        return s[2:0];
    endfunction

    initial begin
        bus.req = 1'b0; bus.datarw = 3'b000; bus.addr = 32'b0; bus.wdata = 32'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_done", {31'b0, bus.done}, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_en_we_be", {26'b0, bus.sram_en, bus.sram_we, bus.sram_be}, 0);
        chk("rst_addr_wd", {22'b0, bus.sram_addr} | bus.sram_wdata, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        access(3'b111, 32'h10, 32'hDEADBEEF);
        chk("sw_lat", lat, 2);
        chk("sw_busy", {31'b0, busy_ok}, 1);
        chk("sw_beats", nb, 1);
        chk("sw_beat", {log_we[ix(first,0)], log_be[ix(first,0)], 18'b0, log_addr[ix(first,0)]}, {1'b1, 4'b1111, 18'b0, 10'd4});
        chk("sw_wd", log_wd[ix(first,0)], 32'hDEADBEEF);
        chk("sw_rdata", got, 0);
        access(3'b100, 32'h10, 32'h0);
        chk("lw_lat", lat, 2);
        chk("lw_we", {31'b0, log_we[ix(first,0)]}, 0);
        chk("lw_rdata", got, 32'hDEADBEEF);

        access(3'b101, 32'h13, 32'h12345680);
        chk("sb_be", {28'b0, log_be[ix(first,0)]}, 4'b1000);
        chk("sb_wd", log_wd[ix(first,0)], 32'h80000000);
        access(3'b000, 32'h13, 32'h0);
        chk("lb_rdata", got, 32'hFFFFFF80);
        access(3'b010, 32'h13, 32'h0);
        chk("lbu_rdata", got, 32'h00000080);

        access(3'b111, 32'h07, 32'h11223344);
        chk("msw_lat", lat, 3);
        chk("msw_beats", nb, 2);
        chk("msw_b0", {log_be[ix(first,0)], 18'b0, log_addr[ix(first,0)]}, {4'b1000, 18'b0, 10'd1});
        chk("msw_b0_wd", log_wd[ix(first,0)], 32'h44000000);
        chk("msw_b1", {log_be[ix(first,1)], 18'b0, log_addr[ix(first,1)]}, {4'b0111, 18'b0, 10'd2});
        chk("msw_b1_wd", log_wd[ix(first,1)], 32'h00112233);
        access(3'b100, 32'h07, 32'h0);
        chk("mlw_lat", lat, 3);
        chk("mlw_rdata", got, 32'h11223344);

        access(3'b111, 32'h1C, 32'h8001ABCD);
        access(3'b001, 32'h1E, 32'h0);
        chk("lh_beats", nb, 1);
        chk("lh_rdata", got, 32'hFFFF8001);
        access(3'b101, 32'h1F, 32'h34);
        access(3'b101, 32'h20, 32'h12);
        access(3'b011, 32'h1F, 32'h0);
        chk("lhu_beats", nb, 2);
        chk("lhu_rdata", got, 32'h00001234);

        access(3'b110, 32'hFFF, 32'h0000AABB);
        chk("wrap_b0", {log_be[ix(first,0)], 18'b0, log_addr[ix(first,0)]}, {4'b1000, 18'b0, 10'd1023});
        chk("wrap_b0_wd", log_wd[ix(first,0)], 32'hBB000000);
        chk("wrap_b1", {log_be[ix(first,1)], 18'b0, log_addr[ix(first,1)]}, {4'b0001, 18'b0, 10'd0});
        chk("wrap_b1_wd", log_wd[ix(first,1)], 32'h000000AA);

        @(negedge clk);
        bus.req = 1'b1; bus.datarw = 3'b111; bus.addr = 32'h0B; bus.wdata = 32'hCAFEF00D;
        first = beats;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= bus.done | bus.sram_en | bus.busy;
        end
        chk("rst_mid_quiet", {31'b0, seen}, 0);
        chk("rst_mid_beats", beats - first, 1);
        chk("rst_mid_word2", mem[2], 32'h0D112233);
        chk("rst_mid_word3", mem[3], 32'h0);

        @(negedge clk);
        bus.req = 1'b1; bus.datarw = 3'b100; bus.addr = 32'h10;
        first = beats;
        @(posedge clk);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen |= bus.done;
        end
        @(posedge clk);
        #1 bus.req = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_req_done", {31'b0, seen}, 1);
        chk("busy_req_beats", beats - first, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
